// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - instruction-memory request/acknowledge bundle for fetch_seq
interface fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - MIPS fetch sequencer: PC, imem handshake, IF/ID skid, delayed redirects
// Optional misaligned-redirect trap: define FETCH_ALIGN_CHK_EN.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    fetch_seq_if.master imem,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_ins,
    output logic        if_adel
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_ins_q, if_ins_d;
    logic        if_adel_q, if_adel_d;

    logic        out_free;
    logic        cap;
    logic        req_int;
    logic        ack_take;
    logic        skid_take;
    logic        exc_take;
    logic        adv;
    logic        tgt_sel;
    logic        tgt_bad;
    logic [31:0] tgt_raw;
    logic [31:0] tgt;

    assign out_free  = !if_valid_q || !stall;
    // The instruction in if_* is the branch; the word after it is its delay slot.
    assign cap       = redir_valid && if_valid_q && !stall;
    assign ack_take  = req_int && imem.imem_ack;
    assign skid_take = (state_q == S_HOLD) && !stall;
    assign adv       = (ack_take && out_free) || skid_take;
    assign tgt_sel   = cap || pend_valid_q;
    assign tgt_raw   = cap ? redir_pc : pend_pc_q;

`ifdef FETCH_ALIGN_CHK_EN
    localparam logic [31:0] EXC_VEC = 32'h0000_4180;

    logic        exc_pend_q, exc_pend_d;
    logic [31:0] exc_pc_q, exc_pc_d;

    assign tgt      = tgt_raw;
    assign tgt_bad  = tgt_sel && (tgt_raw[1:0] != 2'b00);
    // While the trap entry waits for the output slot, memory is left idle.
    assign req_int  = (state_q == S_REQ) && !exc_pend_q;
    assign exc_take = (state_q == S_REQ) && exc_pend_q && out_free;

    always_comb begin
        exc_pend_d = exc_pend_q;
        exc_pc_d   = exc_pc_q;
        if (adv && tgt_bad) begin
            exc_pend_d = 1'b1;
            exc_pc_d   = tgt_raw;
        end else if (exc_take) begin
            exc_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_pend_q <= 1'b0;
            exc_pc_q   <= RESET_PC;
        end else begin
            exc_pend_q <= exc_pend_d;
            exc_pc_q   <= exc_pc_d;
        end
    end
`else
    assign tgt      = tgt_raw & ~32'd3;
    assign tgt_bad  = 1'b0;
    assign req_int  = (state_q == S_REQ);
    assign exc_take = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_ins_d     = if_ins_q;
        if_adel_d    = if_adel_q;

        if (cap) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = redir_pc;
        end

        // A redirect captured this cycle is consumed immediately if pc_q advances now.
        if (adv) begin
            pend_valid_d = 1'b0;
            if (tgt_bad) begin
`ifdef FETCH_ALIGN_CHK_EN
                pc_d = EXC_VEC;
`else
                pc_d = pc_q + 32'd4;
`endif
            end else if (tgt_sel) begin
                pc_d = tgt;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end

        if (ack_take && out_free) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_ins_d   = imem.imem_rdata;
            if_adel_d  = 1'b0;
        end else if (skid_take) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_q;
            if_ins_d   = skid_q;
            if_adel_d  = 1'b0;
        end else if (exc_take) begin
`ifdef FETCH_ALIGN_CHK_EN
            if_valid_d = 1'b1;
            if_pc_d    = exc_pc_q;
            if_ins_d   = 32'h0;
            if_adel_d  = 1'b1;
`endif
        end else if (!stall) begin
            if_valid_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (ack_take && !out_free) begin
                    state_d   = S_HOLD;
                    skid_d    = imem.imem_rdata;
                    skid_pc_d = pc_q;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= RESET_PC;
            skid_q       <= 32'h0;
            skid_pc_q    <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_pc_q      <= RESET_PC;
            if_ins_q     <= 32'h0;
            if_adel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_ins_q     <= if_ins_d;
            if_adel_q    <= if_adel_d;
        end
    end

    assign imem.imem_req  = req_int;
    assign imem.imem_addr = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_ins         = if_ins_q;
    assign if_adel        = if_adel_q;
endmodule
